comparator_result_monitor: RTL and testbench

- Registered stage directly downstream of digital_comparator_5; consumes its 3-bit one-hot result Y and produces per-category sample statistics, change events and a match-lock status.
- Samples Y only when sample_en is high. Flags any Y code that is not one-hot.
- All outputs are registered and drive the lab board LEDs and the 7-seg display logic.

---
 rtl/comparator_result_monitor.sv | 194 +++++++++++++++++++
 tb/tb_comparator_result_monitor.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/comparator_result_monitor.sv
// Registered monitor for a one-hot comparator result. It keeps saturating per-category
// counts, flags change events and non-one-hot codes, and tracks a lock on runs of equal results.
module comparator_result_monitor #(
    parameter int CNT_W     = 8,
    parameter int MATCH_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       y,
    input  logic             sample_en,
    input  logic             clr,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [2:0]       last_y,
    output logic             change,
    output logic             locked,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_TRACK  = 2'b01,
        ST_LOCKED = 2'b10,
        ST_FAULT  = 2'b11
    } state_t;

    localparam logic [3:0]       LP_MATCH = 4'(MATCH_LEN);
    localparam logic [CNT_W-1:0] LP_SAT   = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_run;
    logic [3:0]       w_run_nxt;
    logic [CNT_W-1:0] r_gt_cnt;
    logic [CNT_W-1:0] r_eq_cnt;
    logic [CNT_W-1:0] r_lt_cnt;
    logic [2:0]       r_last_y;
    logic             r_change;
    logic             r_locked;
    logic             r_err;

    logic w_sample;
    logic w_valid;
    logic w_invalid;
    logic w_is_eq;
    logic w_change_nxt;

    function automatic logic f_is_onehot(input logic [2:0] code);
        logic ok;
        case (code)
            3'b100, 3'b010, 3'b001: ok = 1'b1;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] res;
        if (cnt == LP_SAT) begin
            res = cnt;
        end else begin
            res = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    // A clear on the same edge swallows the sample.
    assign w_sample     = sample_en & ~clr;
    assign w_valid      = w_sample & f_is_onehot(y);
    assign w_invalid    = w_sample & ~f_is_onehot(y);
    assign w_is_eq      = (y == 3'b010);
    assign w_change_nxt = w_valid && (r_last_y != 3'b000) && (y != r_last_y);

    // Next-state and eq-run logic for the lock tracker.
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        case (r_state)
            ST_IDLE: begin
                if (w_valid) begin
                    if (w_is_eq) begin
                        w_run_nxt   = 4'd1;
                        w_state_nxt = (LP_MATCH == 4'd1) ? ST_LOCKED : ST_TRACK;
                    end else begin
                        w_run_nxt   = 4'd0;
                        w_state_nxt = ST_TRACK;
                    end
                end else if (w_invalid) begin
                    w_state_nxt = ST_FAULT;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_TRACK: begin
                if (w_valid) begin
                    if (w_is_eq) begin
                        w_run_nxt = r_run + 4'd1;
                        if ((r_run + 4'd1) == LP_MATCH) begin
                            w_state_nxt = ST_LOCKED;
                        end else begin
                            w_state_nxt = ST_TRACK;
                        end
                    end else begin
                        w_run_nxt = 4'd0;
                    end
                end else if (w_invalid) begin
                    w_state_nxt = ST_FAULT;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_LOCKED: begin
                if (w_valid) begin
                    if (w_is_eq) begin
                        w_run_nxt = LP_MATCH;
                    end else begin
                        w_run_nxt   = 4'd0;
                        w_state_nxt = ST_TRACK;
                    end
                end else if (w_invalid) begin
                    w_state_nxt = ST_FAULT;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_FAULT: begin
                w_state_nxt = ST_FAULT;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_run_nxt   = 4'd0;
            end
        endcase
    end

    // State, run counter and the status flags derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_run    <= 4'd0;
            r_locked <= 1'b0;
            r_err    <= 1'b0;
        end else if (clr) begin
            r_state  <= ST_IDLE;
            r_run    <= 4'd0;
            r_locked <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_run    <= w_run_nxt;
            r_locked <= (w_state_nxt == ST_LOCKED);
            r_err    <= (w_state_nxt == ST_FAULT);
        end
    end

    // Category counters, last valid code and the change pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gt_cnt <= {CNT_W{1'b0}};
            r_eq_cnt <= {CNT_W{1'b0}};
            r_lt_cnt <= {CNT_W{1'b0}};
            r_last_y <= 3'b000;
            r_change <= 1'b0;
        end else if (clr) begin
            r_gt_cnt <= {CNT_W{1'b0}};
            r_eq_cnt <= {CNT_W{1'b0}};
            r_lt_cnt <= {CNT_W{1'b0}};
            r_last_y <= 3'b000;
            r_change <= 1'b0;
        end else begin
            r_change <= w_change_nxt;
            if (w_valid) begin
                r_last_y <= y;
                if (y[2]) begin
                    r_gt_cnt <= f_sat_inc(r_gt_cnt);
                end else if (y[1]) begin
                    r_eq_cnt <= f_sat_inc(r_eq_cnt);
                end else begin
                    r_lt_cnt <= f_sat_inc(r_lt_cnt);
                end
            end
        end
    end

    assign gt_cnt = r_gt_cnt;
    assign eq_cnt = r_eq_cnt;
    assign lt_cnt = r_lt_cnt;
    assign last_y = r_last_y;
    assign change = r_change;
    assign locked = r_locked;
    assign err    = r_err;

endmodule

// File: tb/tb_comparator_result_monitor.sv
// Randomized and directed bench for comparator_result_monitor against a
// behavioural model built from the counting, change and lock rules.
module tb_comparator_result_monitor;

    localparam int CNT_W     = 4;
    localparam int MATCH_LEN = 4;
    localparam int SAT       = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic [2:0]       y;
    logic             sample_en;
    logic             clr;
    logic [CNT_W-1:0] gt_cnt;
    logic [CNT_W-1:0] eq_cnt;
    logic [CNT_W-1:0] lt_cnt;
    logic [2:0]       last_y;
    logic             change;
    logic             locked;
    logic             err;

    int n_tests;
    int n_fail;

    // reference model state
    int   m_gt, m_eq, m_lt;
    int   m_last;
    int   m_change;
    int   m_streak;
    int   m_fault;

    comparator_result_monitor #(.CNT_W(CNT_W), .MATCH_LEN(MATCH_LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .y         (y),
        .sample_en (sample_en),
        .clr       (clr),
        .gt_cnt    (gt_cnt),
        .eq_cnt    (eq_cnt),
        .lt_cnt    (lt_cnt),
        .last_y    (last_y),
        .change    (change),
        .locked    (locked),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_gt = 0; m_eq = 0; m_lt = 0;
        m_last = 0; m_change = 0; m_streak = 0; m_fault = 0;
    endtask

    task automatic model_step(input logic [2:0] yv, input logic en, input logic cl);
        bit onehot;
        onehot = (yv == 3'b100) || (yv == 3'b010) || (yv == 3'b001);
        if (cl) begin
            model_clear();
        end else if (en && onehot) begin
            m_change = (m_last != 0 && int'(yv) != m_last) ? 1 : 0;
            m_last   = int'(yv);
            if (yv == 3'b100) m_gt = (m_gt < SAT) ? m_gt + 1 : SAT;
            else if (yv == 3'b010) m_eq = (m_eq < SAT) ? m_eq + 1 : SAT;
            else m_lt = (m_lt < SAT) ? m_lt + 1 : SAT;
            m_streak = (yv == 3'b010) ? m_streak + 1 : 0;
        end else if (en) begin
            m_fault  = 1;
            m_change = 0;
        end else begin
            m_change = 0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".gt"},     int'(gt_cnt), m_gt);
        check({tag, ".eq"},     int'(eq_cnt), m_eq);
        check({tag, ".lt"},     int'(lt_cnt), m_lt);
        check({tag, ".last_y"}, int'(last_y), m_last);
        check({tag, ".change"}, int'(change), m_change);
        check({tag, ".locked"}, int'(locked), (m_fault == 0 && m_streak >= MATCH_LEN) ? 1 : 0);
        check({tag, ".err"},    int'(err),    m_fault);
    endtask

    task automatic cycle(input string tag, input logic [2:0] yv, input logic en, input logic cl);
        y         = yv;
        sample_en = en;
        clr       = cl;
        @(posedge clk);
        model_step(yv, en, cl);
        #1;
        check_all(tag);
        sample_en = 1'b0;
        clr       = 1'b0;
    endtask

    task automatic async_reset_check(input string tag);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_clear();
        check_all(tag);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        y         = 3'b000;
        sample_en = 1'b0;
        clr       = 1'b0;
        model_clear();
        #12;
        check_all("reset");
        rst_n = 1'b1;
        cycle("idle", 3'b000, 1'b0, 1'b0);

        // category counting, with an idle gap between the two GT pulses
        cycle("cat1", 3'b100, 1'b1, 1'b0);
        cycle("cat_gap", 3'b100, 1'b0, 1'b0);
        cycle("cat2", 3'b100, 1'b1, 1'b0);
        cycle("cat3", 3'b001, 1'b1, 1'b0);
        check("cat3_change", int'(change), 1);
        cycle("cat4", 3'b010, 1'b1, 1'b0);
        check("cat_gt", int'(gt_cnt), 2);
        check("cat_lt", int'(lt_cnt), 1);
        check("cat_eq", int'(eq_cnt), 1);
        check("cat_last", int'(last_y), 2);
        check("cat4_change", int'(change), 1);
        cycle("cat_after", 3'b000, 1'b0, 1'b0);

        // lock entry and exit
        cycle("clr_a", 3'b000, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle("lock_eq", 3'b010, 1'b1, 1'b0);
            if (i == 2) check("lock_not_yet", int'(locked), 0);
        end
        check("lock_set", int'(locked), 1);
        cycle("lock_gt", 3'b100, 1'b1, 1'b0);
        check("lock_drop", int'(locked), 0);

        // broken run never locks
        cycle("clr_b", 3'b000, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            cycle("run_brk", (i == 3) ? 3'b100 : 3'b010, 1'b1, 1'b0);
        end
        check("run_brk_lock", int'(locked), 0);

        // saturation
        cycle("clr_c", 3'b000, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) cycle("sat", 3'b100, 1'b1, 1'b0);
        check("sat_gt", int'(gt_cnt), SAT);

        // invalid code, recovery by clear
        cycle("clr_d", 3'b000, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle("pre_inv", 3'b010, 1'b1, 1'b0);
        cycle("inv", 3'b110, 1'b1, 1'b0);
        check("inv_err", int'(err), 1);
        check("inv_lock", int'(locked), 0);
        cycle("inv_eq", 3'b010, 1'b1, 1'b0);
        check("inv_eq_lock", int'(locked), 0);
        cycle("inv_clr", 3'b000, 1'b0, 1'b1);
        check("inv_clr_err", int'(err), 0);
        for (int i = 0; i < 4; i++) cycle("relock", 3'b010, 1'b1, 1'b0);
        check("relock_set", int'(locked), 1);

        // clear wins over a simultaneous sample
        cycle("clr_pri", 3'b100, 1'b1, 1'b1);
        check("clr_pri_gt", int'(gt_cnt), 0);
        check("clr_pri_last", int'(last_y), 0);

        // mid-cycle async reset after some history
        cycle("pre_rst", 3'b001, 1'b1, 1'b0);
        async_reset_check("async_rst");
        cycle("post_rst", 3'b100, 1'b1, 1'b0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] yv;
            logic       en;
            logic       cl;
            case ($urandom_range(0, 9))
                0:       yv = 3'($urandom_range(0, 7));
                1, 2, 3: yv = 3'b100;
                4, 5:    yv = 3'b001;
                default: yv = 3'b010;
            endcase
            en = ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0;
            cl = ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0;
            cycle("rand", yv, en, cl);
            if (i == 1500) async_reset_check("rand_rst");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
